// File: rtl/wb_rr_arb5.sv
// Five-master round-robin Wishbone arbiter producing a registered one-hot grant.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arb5 #(
  parameter int MAX_HOLD = 256,
  parameter int CNT_W    = 9
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [4:0] req,
  input  logic       ack,
  output logic [4:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;

  logic [0:0] state;
  logic [2:0] last;
  logic [2:0] nxt;
  logic [2:0] idx;
  logic       any;

  // Search last+1, last+2, ... with an explicit 4 -> 0 wrap
  always_comb begin
    nxt = last;
    any = 1'b0;
    idx = last;
    for (int unsigned i = 0; i < 5; i++) begin
      idx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      if (!any && req[idx]) begin
        nxt = idx;
        any = 1'b1;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] count;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      last    <= 3'd4;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      count   <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any) begin
            gnt    <= 5'b00001 << nxt;
            gnt_id <= nxt;
            busy   <= 1'b1;
            count  <= '0;
            state  <= S_OWN;
          end
        end
        default: begin
          if (!req[gnt_id]) begin
            gnt   <= '0;
            busy  <= 1'b0;
            last  <= gnt_id;
            state <= S_IDLE;
          end else if (ack) begin
            count <= '0;
          end else if (count == CNT_W'(MAX_HOLD - 1)) begin
            // Hung owner is treated exactly like a voluntary release
            gnt     <= '0;
            busy    <= 1'b0;
            last    <= gnt_id;
            timeout <= 1'b1;
            state   <= S_IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
      endcase
    end
  end
`else
  logic unused_ack;
  logic unused_cfg;
  assign unused_ack = ack;
  assign unused_cfg = (MAX_HOLD < (2 ** CNT_W));
  assign timeout    = 1'b0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= S_IDLE;
      last   <= 3'd4;
      gnt    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any) begin
            gnt    <= 5'b00001 << nxt;
            gnt_id <= nxt;
            busy   <= 1'b1;
            state  <= S_OWN;
          end
        end
        default: begin
          if (!req[gnt_id]) begin
            gnt   <= '0;
            busy  <= 1'b0;
            last  <= gnt_id;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_wb_rr_arb5.sv
// Directed self-checking bench for wb_rr_arb5 (watchdog cases need WB_ARB_TIMEOUT_EN).
module tb_wb_rr_arb5;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int MH = 8;
  localparam int CW = 4;
`else
  localparam int MH = 256;
  localparam int CW = 9;
`endif

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic [4:0] req;
  logic       ack;
  logic [4:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  wb_rr_arb5 #(.MAX_HOLD(MH), .CNT_W(CW)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .req      (req),
    .ack      (ack),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic       rst;
    logic [4:0] req;
    logic [4:0] gnt;
    logic [2:0] id;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later
  task automatic step(input logic r, input logic [4:0] q, input logic a);
    wb_rst_i = r;
    req      = q;
    ack      = a;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic expect_state(input string name, input int tag, input logic [4:0] eg,
                              input logic [2:0] eid, input logic eto);
    chk({name, ".gnt"}, tag, {3'b0, gnt}, {3'b0, eg});
    chk({name, ".busy"}, tag, {7'b0, busy}, {7'b0, |eg});
    chk({name, ".timeout"}, tag, {7'b0, timeout}, {7'b0, eto});
    if (|eg) chk({name, ".gnt_id"}, tag, {5'b0, gnt_id}, {5'b0, eid});
  endtask

  function automatic void add(input logic r, input logic [4:0] q, input logic [4:0] g, input logic [2:0] i);
    vec_t v;
    v.rst = r; v.req = q; v.gnt = g; v.id = i;
    tbl.push_back(v);
  endfunction

  initial begin
    wb_rst_i = 1'b1;
    req      = '0;
    ack      = 1'b0;

    // Basic sequence: 0, 2, 4 with a free cycle between owners
    add(1, 5'b00000, 5'b00000, 0);
    add(0, 5'b10101, 5'b00001, 0);
    add(0, 5'b10101, 5'b00001, 0);
    add(0, 5'b10100, 5'b00000, 0);
    add(0, 5'b10100, 5'b00100, 2);
    add(0, 5'b10000, 5'b00000, 0);
    add(0, 5'b10000, 5'b10000, 4);
    add(0, 5'b00000, 5'b00000, 0);
    add(0, 5'b00000, 5'b00000, 0);
    // Release of 1 coincides with req[0]; search from 2 reaches 4 first
    add(0, 5'b00010, 5'b00010, 1);
    add(0, 5'b10010, 5'b00010, 1);
    add(0, 5'b10001, 5'b00000, 0);
    add(0, 5'b10001, 5'b10000, 4);
    add(0, 5'b00000, 5'b00000, 0);
    add(0, 5'b00000, 5'b00000, 0);
    // Lone requester 3: re-granted after exactly one idle cycle
    for (int k = 0; k < 2; k++) begin
      add(0, 5'b01000, 5'b01000, 3);
      add(0, 5'b01000, 5'b01000, 3);
      add(0, 5'b01000, 5'b01000, 3);
      add(0, 5'b01000, 5'b01000, 3);
      add(0, 5'b00000, 5'b00000, 0);
    end
    add(0, 5'b00000, 5'b00000, 0);
    // Reset while 2 owns: pointer returns to 4 so master 1 wins
    add(0, 5'b00100, 5'b00100, 2);
    add(0, 5'b00110, 5'b00100, 2);
    add(1, 5'b00110, 5'b00000, 0);
    add(0, 5'b00110, 5'b00010, 1);
    add(0, 5'b00000, 5'b00000, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, 1'b0);
      expect_state("vec", i, tbl[i].gnt, tbl[i].id, 1'b0);
    end

    // Full contention: each owner holds 3 cycles, drops req for one
    step(1, 5'b00000, 0);
    expect_state("rot_rst", 0, 5'b00000, 0, 0);
    for (int k = 0; k < 6; k++) begin
      logic [2:0] o;
      logic [4:0] oh;
      o  = 3'(k % 5);
      oh = 5'b00001 << o;
      step(0, 5'b11111, 0);
      expect_state("rot_gnt", k, oh, o, 0);
      step(0, 5'b11111, 0);
      step(0, 5'b11111, 0);
      expect_state("rot_hold", k, oh, o, 0);
      step(0, 5'b11111 & ~oh, 0);
      expect_state("rot_rel", k, 5'b00000, 0, 0);
    end

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog fires at the end of the 8th ownership cycle without ack
    step(1, 5'b00000, 0);
    step(0, 5'b00001, 0);
    expect_state("wd_gnt", 0, 5'b00001, 0, 0);
    for (int k = 0; k < MH - 1; k++) begin
      step(0, 5'b00001, 0);
      expect_state("wd_hold", k, 5'b00001, 0, 0);
    end
    step(0, 5'b00011, 0);
    expect_state("wd_fire", 0, 5'b00000, 0, 1);
    step(0, 5'b00011, 0);
    expect_state("wd_next", 0, 5'b00010, 1, 0);

    // Periodic ack keeps the watchdog from firing
    step(1, 5'b00000, 0);
    step(0, 5'b00001, 0);
    for (int k = 0; k < 24; k++) begin
      step(0, 5'b00001, (k % 5) == 4);
      expect_state("wd_ack", k, 5'b00001, 0, 0);
    end
`else
    // Without the watchdog a long silent hold is never broken
    step(1, 5'b00000, 0);
    step(0, 5'b00001, 0);
    for (int k = 0; k < 300; k++) step(0, 5'b00011, 0);
    expect_state("nowd_hold", 0, 5'b00001, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
